bank64k_arbiter: RTL and testbench



---
 rtl/bank_arb_pkg.sv | 28 ++
 rtl/bank64k_arbiter_rr_arb3.sv | 50 +++++
 rtl/bank64k_arbiter.sv | 132 +++++++++++++
 tb/tb_bank64k_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bank_arb_pkg.sv
// Shared constants for the three-requester bank arbiter: requester ids and
// the bank write-data mux codes.
package bank_arb_pkg;

  localparam int unsigned N_REQ = 3;
  localparam int unsigned ID_W  = 2;

  localparam logic [ID_W-1:0] REQ_I = 2'd0;
  localparam logic [ID_W-1:0] REQ_D = 2'd1;
  localparam logic [ID_W-1:0] REQ_C = 2'd2;

  localparam logic [1:0] MUX_I    = 2'b00;
  localparam logic [1:0] MUX_D    = 2'b01;
  localparam logic [1:0] MUX_C    = 2'b10;
  localparam logic [1:0] MUX_NONE = 2'b11;

  // One-hot grant vector {c,d,i} to requester id; zero maps to REQ_I.
  function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_REQ-1:0] oh);
    logic [ID_W-1:0] id;
    case (oh)
      3'b010:  id = REQ_D;
      3'b100:  id = REQ_C;
      default: id = REQ_I;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/bank64k_arbiter_rr_arb3.sv
// Three-way round-robin arbiter. win is the unmasked round-robin choice;
// gnt is win unless block is high. last advances only on an issued grant.
module rr_arb3
  import bank_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             block,
  output logic [N_REQ-1:0] win,
  output logic [N_REQ-1:0] gnt
);

  logic [ID_W-1:0]  r_last;
  logic [N_REQ-1:0] w_win;

  // Priority starts at the requester after the last one granted.
  always_comb begin
    w_win = '0;
    case (r_last)
      REQ_I: begin
        if      (req[1]) w_win = 3'b010;
        else if (req[2]) w_win = 3'b100;
        else if (req[0]) w_win = 3'b001;
      end
      REQ_D: begin
        if      (req[2]) w_win = 3'b100;
        else if (req[0]) w_win = 3'b001;
        else if (req[1]) w_win = 3'b010;
      end
      default: begin
        if      (req[0]) w_win = 3'b001;
        else if (req[1]) w_win = 3'b010;
        else if (req[2]) w_win = 3'b100;
      end
    endcase
  end

  assign win = w_win;
  assign gnt = block ? '0 : w_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ_C;
    end else if (|gnt) begin
      r_last <= onehot_to_id(gnt);
    end
  end

endmodule

// File: rtl/bank64k_arbiter.sv
// Arbitrates one bank's write and read ports among requesters i/d/c and
// tags in-flight reads so each requester knows when the read word is its own.
module bank64k_arbiter
  import bank_arb_pkg::*;
#(
  parameter int unsigned A     = 10,
  parameter int unsigned RDLAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         wr_req_i,
  input  logic         wr_req_d,
  input  logic         wr_req_c,
  input  logic [A-1:0] wr_addr_i,
  input  logic [A-1:0] wr_addr_d,
  input  logic [A-1:0] wr_addr_c,
  output logic         wr_gnt_i,
  output logic         wr_gnt_d,
  output logic         wr_gnt_c,

  input  logic         rd_req_i,
  input  logic         rd_req_d,
  input  logic         rd_req_c,
  input  logic [A-1:0] rd_addr_i,
  input  logic [A-1:0] rd_addr_d,
  input  logic [A-1:0] rd_addr_c,
  output logic         rd_gnt_i,
  output logic         rd_gnt_d,
  output logic         rd_gnt_c,
  output logic         rd_vld_i,
  output logic         rd_vld_d,
  output logic         rd_vld_c,

  output logic         bank_wr_en,
  output logic [A-1:0] bank_wr_addr,
  output logic [1:0]   bank_wr_muxcode,
  output logic         bank_rd_en,
  output logic [A-1:0] bank_rd_addr
);

  logic [N_REQ-1:0] w_wr_req;
  logic [N_REQ-1:0] w_rd_req;
  logic [N_REQ-1:0] w_wr_win;
  logic [N_REQ-1:0] w_wr_gnt;
  logic [N_REQ-1:0] w_rd_win;
  logic [N_REQ-1:0] w_rd_gnt;
  logic [A-1:0]     w_wr_win_addr;
  logic [1:0]       w_wr_win_mux;
  logic [A-1:0]     w_rd_win_addr;
  logic             w_collide;

  logic [RDLAT-1:0] r_tag_vld;
  logic [ID_W-1:0]  r_tag_id [RDLAT];

  assign w_wr_req = {wr_req_c, wr_req_d, wr_req_i};
  assign w_rd_req = {rd_req_c, rd_req_d, rd_req_i};

  rr_arb3 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_wr_req),
    .block (1'b0),
    .win   (w_wr_win),
    .gnt   (w_wr_gnt)
  );

  rr_arb3 u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_rd_req),
    .block (w_collide),
    .win   (w_rd_win),
    .gnt   (w_rd_gnt)
  );

  // Address and muxcode of each port's round-robin winner.
  always_comb begin
    w_wr_win_addr = '0;
    w_wr_win_mux  = MUX_NONE;
    case (w_wr_win)
      3'b001: begin w_wr_win_addr = wr_addr_i; w_wr_win_mux = MUX_I; end
      3'b010: begin w_wr_win_addr = wr_addr_d; w_wr_win_mux = MUX_D; end
      3'b100: begin w_wr_win_addr = wr_addr_c; w_wr_win_mux = MUX_C; end
      default: ;
    endcase
  end

  always_comb begin
    w_rd_win_addr = '0;
    case (w_rd_win)
      3'b001:  w_rd_win_addr = rd_addr_i;
      3'b010:  w_rd_win_addr = rd_addr_d;
      3'b100:  w_rd_win_addr = rd_addr_c;
      default: ;
    endcase
  end

  // A read to the address being written this cycle waits; the write goes first.
  assign w_collide = (|w_wr_gnt) && (|w_rd_win) && (w_rd_win_addr == w_wr_win_addr);

  assign {wr_gnt_c, wr_gnt_d, wr_gnt_i} = w_wr_gnt;
  assign {rd_gnt_c, rd_gnt_d, rd_gnt_i} = w_rd_gnt;

  assign bank_wr_en      = |w_wr_gnt;
  assign bank_wr_addr    = bank_wr_en ? w_wr_win_addr : '0;
  assign bank_wr_muxcode = bank_wr_en ? w_wr_win_mux  : MUX_NONE;
  assign bank_rd_en      = |w_rd_gnt;
  assign bank_rd_addr    = bank_rd_en ? w_rd_win_addr : '0;

  // Tag pipeline: one stage per cycle of bank read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int s = 0; s < int'(RDLAT); s++) begin
        r_tag_id[s] <= REQ_I;
      end
    end else begin
      r_tag_vld[0] <= |w_rd_gnt;
      r_tag_id[0]  <= onehot_to_id(w_rd_gnt);
      for (int s = 1; s < int'(RDLAT); s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  assign rd_vld_i = r_tag_vld[RDLAT-1] && (r_tag_id[RDLAT-1] == REQ_I);
  assign rd_vld_d = r_tag_vld[RDLAT-1] && (r_tag_id[RDLAT-1] == REQ_D);
  assign rd_vld_c = r_tag_vld[RDLAT-1] && (r_tag_id[RDLAT-1] == REQ_C);

endmodule

// File: tb/tb_bank64k_arbiter.sv
// Directed bench: three arbiter instances (RDLAT 1, 2, 3) share the same
// stimulus; grants are checked on instance 0, read-valid on every instance.
module tb_bank64k_arbiter;

  localparam int unsigned A    = 10;
  localparam int unsigned NROW = 18;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]   wr_req, rd_req;
  logic [A-1:0] wa_i, wa_d, wa_c, ra_i, ra_d, ra_c;

  logic [2:0][2:0]   wg, rg, vld;
  logic [2:0]        bwe, bre;
  logic [2:0][A-1:0] bwa, bra;
  logic [2:0][1:0]   bmux;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bank64k_arbiter #(.A(A), .RDLAT(g + 1)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .wr_req_i        (wr_req[0]),
      .wr_req_d        (wr_req[1]),
      .wr_req_c        (wr_req[2]),
      .wr_addr_i       (wa_i),
      .wr_addr_d       (wa_d),
      .wr_addr_c       (wa_c),
      .wr_gnt_i        (wg[g][0]),
      .wr_gnt_d        (wg[g][1]),
      .wr_gnt_c        (wg[g][2]),
      .rd_req_i        (rd_req[0]),
      .rd_req_d        (rd_req[1]),
      .rd_req_c        (rd_req[2]),
      .rd_addr_i       (ra_i),
      .rd_addr_d       (ra_d),
      .rd_addr_c       (ra_c),
      .rd_gnt_i        (rg[g][0]),
      .rd_gnt_d        (rg[g][1]),
      .rd_gnt_c        (rg[g][2]),
      .rd_vld_i        (vld[g][0]),
      .rd_vld_d        (vld[g][1]),
      .rd_vld_c        (vld[g][2]),
      .bank_wr_en      (bwe[g]),
      .bank_wr_addr    (bwa[g]),
      .bank_wr_muxcode (bmux[g]),
      .bank_rd_en      (bre[g]),
      .bank_rd_addr    (bra[g])
    );
  end

  typedef struct {
    logic [2:0]   wq, rq;
    logic [A-1:0] wai, wad, wac, rai, rad, rac;
    logic [2:0]   ewg, erg;
    logic [1:0]   emux;
    logic [A-1:0] ewa, era;
  } vec_t;

  vec_t tbl [NROW];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t row(input logic [2:0] wq, input logic [2:0] rq,
                               input logic [A-1:0] wai, input logic [A-1:0] wad,
                               input logic [A-1:0] wac, input logic [A-1:0] rai,
                               input logic [A-1:0] rad, input logic [A-1:0] rac,
                               input logic [2:0] ewg, input logic [2:0] erg,
                               input logic [1:0] emux, input logic [A-1:0] ewa,
                               input logic [A-1:0] era);
    vec_t v;
    v.wq = wq; v.rq = rq;
    v.wai = wai; v.wad = wad; v.wac = wac;
    v.rai = rai; v.rad = rad; v.rac = rac;
    v.ewg = ewg; v.erg = erg; v.emux = emux; v.ewa = ewa; v.era = era;
    return v;
  endfunction

  task automatic idle();
    wr_req = '0; rd_req = '0;
    wa_i = '0; wa_d = '0; wa_c = '0;
    ra_i = '0; ra_d = '0; ra_c = '0;
  endtask

  // Ends at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " bank_wr_en"},  32'(bwe[0]),  32'(0));
    chk({tag, " bank_wr_mux"}, 32'(bmux[0]), 32'(3));
    chk({tag, " bank_wr_addr"},32'(bwa[0]),  32'(0));
    chk({tag, " bank_rd_en"},  32'(bre[0]),  32'(0));
    chk({tag, " bank_rd_addr"},32'(bra[0]),  32'(0));
    chk({tag, " rd_vld all"},  32'(vld),     32'(0));
  endtask

  initial begin
    // {c,d,i} bit order for all request/grant vectors.
    tbl[0]  = row(3'b111, 3'b000, 10'h001, 10'h002, 10'h003, 0, 0, 0, 3'b001, 3'b000, 2'b00, 10'h001, 10'h000);
    tbl[1]  = row(3'b111, 3'b000, 10'h001, 10'h002, 10'h003, 0, 0, 0, 3'b010, 3'b000, 2'b01, 10'h002, 10'h000);
    tbl[2]  = row(3'b111, 3'b000, 10'h001, 10'h002, 10'h003, 0, 0, 0, 3'b100, 3'b000, 2'b10, 10'h003, 10'h000);
    tbl[3]  = row(3'b111, 3'b000, 10'h001, 10'h002, 10'h003, 0, 0, 0, 3'b001, 3'b000, 2'b00, 10'h001, 10'h000);
    tbl[4]  = row(3'b111, 3'b000, 10'h001, 10'h002, 10'h003, 0, 0, 0, 3'b010, 3'b000, 2'b01, 10'h002, 10'h000);
    tbl[5]  = row(3'b111, 3'b000, 10'h001, 10'h002, 10'h003, 0, 0, 0, 3'b100, 3'b000, 2'b10, 10'h003, 10'h000);
    tbl[6]  = row(3'b000, 3'b111, 0, 0, 0, 10'h100, 10'h101, 10'h102, 3'b000, 3'b001, 2'b11, 10'h000, 10'h100);
    tbl[7]  = row(3'b000, 3'b110, 0, 0, 0, 10'h100, 10'h101, 10'h102, 3'b000, 3'b010, 2'b11, 10'h000, 10'h101);
    tbl[8]  = row(3'b000, 3'b001, 0, 0, 0, 10'h100, 10'h101, 10'h102, 3'b000, 3'b001, 2'b11, 10'h000, 10'h100);
    tbl[9]  = row(3'b100, 3'b001, 0, 0, 10'h3FF, 10'h3FF, 0, 0, 3'b100, 3'b000, 2'b10, 10'h3FF, 10'h000);
    tbl[10] = row(3'b000, 3'b001, 0, 0, 0, 10'h3FF, 0, 0, 3'b000, 3'b001, 2'b11, 10'h000, 10'h3FF);
    tbl[11] = row(3'b010, 3'b010, 0, 10'h010, 0, 0, 10'h020, 0, 3'b010, 3'b010, 2'b01, 10'h010, 10'h020);
    tbl[12] = row(3'b001, 3'b101, 10'h055, 0, 0, 10'h055, 0, 10'h066, 3'b001, 3'b100, 2'b00, 10'h055, 10'h066);
    tbl[13] = row(3'b010, 3'b011, 0, 10'h077, 0, 10'h077, 10'h011, 0, 3'b010, 3'b000, 2'b01, 10'h077, 10'h000);
    tbl[14] = row(3'b000, 3'b011, 0, 0, 0, 10'h077, 10'h011, 0, 3'b000, 3'b001, 2'b11, 10'h000, 10'h077);
    tbl[15] = row(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 2'b11, 10'h000, 10'h000);
    tbl[16] = tbl[15];
    tbl[17] = tbl[15];

    rst_n = 1'b0;
    idle();
    do_reset();
    #2;
    chk_idle_outputs("reset");

    // Table: one row per cycle; rd_vld of the RDLAT=L instance must echo row k-L's read grant.
    for (int k = 0; k < int'(NROW); k++) begin
      wr_req = tbl[k].wq; rd_req = tbl[k].rq;
      wa_i = tbl[k].wai; wa_d = tbl[k].wad; wa_c = tbl[k].wac;
      ra_i = tbl[k].rai; ra_d = tbl[k].rad; ra_c = tbl[k].rac;
      #1;
      chk($sformatf("row%0d wr_gnt", k),   32'(wg[0]),   32'(tbl[k].ewg));
      chk($sformatf("row%0d rd_gnt", k),   32'(rg[0]),   32'(tbl[k].erg));
      chk($sformatf("row%0d wr_en", k),    32'(bwe[0]),  32'(|tbl[k].ewg));
      chk($sformatf("row%0d wr_mux", k),   32'(bmux[0]), 32'(tbl[k].emux));
      chk($sformatf("row%0d wr_addr", k),  32'(bwa[0]),  32'(tbl[k].ewa));
      chk($sformatf("row%0d rd_en", k),    32'(bre[0]),  32'(|tbl[k].erg));
      chk($sformatf("row%0d rd_addr", k),  32'(bra[0]),  32'(tbl[k].era));
      for (int l = 1; l <= 3; l++) begin
        chk($sformatf("row%0d rd_vld lat%0d", k, l), 32'(vld[l-1]),
            32'((k >= l) ? tbl[k-l].erg : 3'b000));
      end
      @(negedge clk);
    end

    // Single read to d at 0x05, latency 1.
    do_reset();
    rd_req = 3'b010; ra_d = 10'h005;
    #2;
    chk("seqA rd_gnt", 32'(rg[0]), 32'(3'b010));
    chk("seqA rd_en",  32'(bre[0]), 32'(1));
    chk("seqA rd_addr",32'(bra[0]), 32'(10'h005));
    chk("seqA vld N",  32'(vld[0]), 32'(0));
    @(negedge clk); idle(); #2;
    chk("seqA vld N+1", 32'(vld[0]), 32'(3'b010));
    @(negedge clk); #2;
    chk("seqA vld N+2", 32'(vld[0]), 32'(0));

    // Reads to c, i, c back to back, latency 3.
    do_reset();
    rd_req = 3'b100; #2; chk("seqB gnt0", 32'(rg[0]), 32'(3'b100));
    @(negedge clk); rd_req = 3'b001; #2; chk("seqB gnt1", 32'(rg[0]), 32'(3'b001));
    @(negedge clk); rd_req = 3'b100; #2; chk("seqB gnt2", 32'(rg[0]), 32'(3'b100));
    chk("seqB vld3 N+2", 32'(vld[2]), 32'(0));
    @(negedge clk); idle(); #2; chk("seqB vld3 N+3", 32'(vld[2]), 32'(3'b100));
    @(negedge clk); #2; chk("seqB vld3 N+4", 32'(vld[2]), 32'(3'b001));
    @(negedge clk); #2; chk("seqB vld3 N+5", 32'(vld[2]), 32'(3'b100));
    @(negedge clk); #2; chk("seqB vld3 N+6", 32'(vld[2]), 32'(0));

    // Reset one cycle after a read grant must flush the tag pipeline.
    do_reset();
    rd_req = 3'b001; #2; chk("seqC gnt", 32'(rg[0]), 32'(3'b001));
    @(negedge clk); idle(); rst_n = 1'b0; #2;
    chk("seqC vld in reset", 32'(vld), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2; chk($sformatf("seqC vld after release %0d", c), 32'(vld), 32'(0));
      @(negedge clk);
    end
    wr_req = 3'b111; rd_req = 3'b111;
    ra_i = 10'h001; ra_d = 10'h002; ra_c = 10'h003;
    #2;
    chk("seqC first rd_gnt", 32'(rg[0]), 32'(3'b001));
    chk("seqC first wr_gnt", 32'(wg[0]), 32'(3'b001));
    @(negedge clk); idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
